mmio_ctrl: RTL and testbench

Memory-mapped I/O responder on the data-memory side of the core: it consumes the address, lane-aligned store data and byte write enables that the execute stage produces for accesses in the I/O region, and returns load data one cycle later with the same latency as data memory. It owns the UART transmit holding register, a receive FIFO, and the cycle and retired-instruction counters. It sits beside dmem in the memory stage; the load-data mux selects `rdata_o` when the registered address lies in the I/O region.

---
 rtl/mmio_ctrl.sv | 159 +++++++++++++++
 tb/tb_mmio_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: memory-mapped I/O responder in the memory stage.
//
// Decodes accesses in the 0x8xxx_xxxx region and returns load data one cycle
// later, matching data-memory latency. Owns the UART TX holding register,
// the UART RX FIFO and the cycle / retired-instruction counters.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   addr_i            byte address of the load/store (ALU result)
//   wdata_i, we_i     lane-aligned store data and byte write enables
//   re_i              load request this cycle
//   inst_retire_i     one instruction retired this cycle
//   rdata_o           registered load data, valid the cycle after re_i
//   uart_tx_*         TX byte / valid out, ready in
//   uart_rx_*         RX byte / valid in, ready out (FIFO not full)
module mmio_ctrl #(
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  we_i,
  input  logic        re_i,
  input  logic        inst_retire_i,
  output logic [31:0] rdata_o,
  output logic [7:0]  uart_tx_data_o,
  output logic        uart_tx_valid_o,
  input  logic        uart_tx_ready_i,
  input  logic [7:0]  uart_rx_data_i,
  input  logic        uart_rx_valid_i,
  output logic        uart_rx_ready_o
);

  localparam int PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Word offsets within the I/O region (addr_i[27:2]).
  localparam logic [25:0] OFF_STATUS = 26'h0;
  localparam logic [25:0] OFF_RXDATA = 26'h1;
  localparam logic [25:0] OFF_TXDATA = 26'h2;
  localparam logic [25:0] OFF_CYCLE  = 26'h4;
  localparam logic [25:0] OFF_INSTR  = 26'h5;
  localparam logic [25:0] OFF_CLEAR  = 26'h6;

  logic             sel;
  logic             rd_en;
  logic             st_en;
  logic [25:0]      off;

  logic [31:0]      rdata_d,    rdata_q;
  logic [31:0]      rd_word;
  logic             tx_valid_d, tx_valid_q;
  logic [7:0]       tx_data_d,  tx_data_q;
  logic [31:0]      cyc_cnt_d,  cyc_cnt_q;
  logic [31:0]      inst_cnt_d, inst_cnt_q;

  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [PTR_W-1:0] rx_wptr_d,  rx_wptr_q;
  logic [PTR_W-1:0] rx_rptr_d,  rx_rptr_q;
  logic [CNT_W-1:0] rx_count_d, rx_count_q;
  logic             rx_empty;
  logic             rx_full;
  logic             rx_push;
  logic             rx_pop;
  logic             tx_hs;
  logic             tx_wr;
  logic             cnt_clr;

  // Byte-offset bits and upper store lanes carry no information here.
  logic unused_bits;
  assign unused_bits = ^{addr_i[1:0], wdata_i[31:8]};

  assign sel   = (addr_i[31:28] == 4'h8);
  assign off   = addr_i[27:2];
  assign rd_en = sel & re_i;
  assign st_en = sel & (|we_i);

  assign rx_empty = (rx_count_q == '0);
  assign rx_full  = (rx_count_q == CNT_W'(RX_DEPTH));
  assign rx_push  = uart_rx_valid_i & ~rx_full;
  assign rx_pop   = rd_en & (off == OFF_RXDATA) & ~rx_empty;

  // A write landing in the handshake cycle is dropped: status showed busy.
  assign tx_hs   = tx_valid_q & uart_tx_ready_i;
  assign tx_wr   = st_en & (off == OFF_TXDATA) & we_i[0];
  assign cnt_clr = st_en & (off == OFF_CLEAR);

  always_comb begin
    rd_word = '0;
    unique case (off)
      OFF_STATUS: rd_word = {30'd0, ~rx_empty, ~tx_valid_q};
      OFF_RXDATA: rd_word = rx_empty ? 32'd0 : {24'd0, rx_mem_q[rx_rptr_q]};
      OFF_CYCLE:  rd_word = cyc_cnt_q;
      OFF_INSTR:  rd_word = inst_cnt_q;
      default:    rd_word = '0;
    endcase
  end

  always_comb begin
    rdata_d    = rd_en ? rd_word : rdata_q;

    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (tx_hs) begin
      tx_valid_d = 1'b0;
    end else if (tx_wr && !tx_valid_q) begin
      tx_valid_d = 1'b1;
      tx_data_d  = wdata_i[7:0];
    end

    rx_wptr_d  = rx_push ? rx_wptr_q + PTR_W'(1) : rx_wptr_q;
    rx_rptr_d  = rx_pop  ? rx_rptr_q + PTR_W'(1) : rx_rptr_q;
    rx_count_d = rx_count_q;
    if (rx_push && !rx_pop)      rx_count_d = rx_count_q + CNT_W'(1);
    else if (!rx_push && rx_pop) rx_count_d = rx_count_q - CNT_W'(1);

    if (cnt_clr) begin
      cyc_cnt_d  = '0;
      inst_cnt_d = '0;
    end else begin
      cyc_cnt_d  = cyc_cnt_q + 32'd1;
      inst_cnt_d = inst_retire_i ? inst_cnt_q + 32'd1 : inst_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_count_q <= '0;
      cyc_cnt_q  <= '0;
      inst_cnt_q <= '0;
    end else begin
      rdata_q    <= rdata_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_count_q <= rx_count_d;
      cyc_cnt_q  <= cyc_cnt_d;
      inst_cnt_q <= inst_cnt_d;
    end
  end

  // FIFO storage holds data only; occupancy is tracked by the count.
  always_ff @(posedge clk) begin
    if (rx_push && !rst) rx_mem_q[rx_wptr_q] <= uart_rx_data_i;
  end

  assign rdata_o         = rdata_q;
  assign uart_tx_valid_o = tx_valid_q;
  assign uart_tx_data_o  = tx_data_q;
  assign uart_rx_ready_o = ~rx_full;

endmodule

// File: tb/tb_mmio_ctrl.sv
module tb_mmio_ctrl;
  localparam int RX_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  we = '0;
  logic        re = 1'b0;
  logic        retire = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [31:0] m_rdata;
  logic        m_txv;
  logic [7:0]  m_txd;
  logic [7:0]  m_q[$];
  logic [31:0] m_cyc;
  logic [31:0] m_inst;

  always #5 clk = ~clk;

  mmio_ctrl #(.RX_DEPTH(RX_DEPTH)) dut (
    .clk(clk), .rst(rst), .addr_i(addr), .wdata_i(wdata), .we_i(we),
    .re_i(re), .inst_retire_i(retire), .rdata_o(rdata),
    .uart_tx_data_o(tx_data), .uart_tx_valid_o(tx_valid),
    .uart_tx_ready_i(tx_ready), .uart_rx_data_i(rx_data),
    .uart_rx_valid_i(rx_valid), .uart_rx_ready_o(rx_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural model: one call per rising edge, using inputs and pre-edge state.
  task automatic model_update();
    logic        sel;
    logic [31:0] w;
    int          pre_size;
    if (rst) begin
      m_rdata = 0; m_txv = 0; m_txd = 0; m_q.delete(); m_cyc = 0; m_inst = 0;
      return;
    end
    sel = (addr[31:28] == 4'h8);
    w = {addr[31:2], 2'b00};
    pre_size = m_q.size();
    if (re && sel) begin
      case (w)
        32'h8000_0000: m_rdata = {30'd0, pre_size != 0, !m_txv};
        32'h8000_0004: m_rdata = (pre_size > 0) ? {24'd0, m_q.pop_front()} : 32'd0;
        32'h8000_0010: m_rdata = m_cyc;
        32'h8000_0014: m_rdata = m_inst;
        default:       m_rdata = 0;
      endcase
    end
    if (rx_valid && pre_size < RX_DEPTH) m_q.push_back(rx_data);
    if (m_txv && tx_ready) m_txv = 0;
    else if (!m_txv && sel && w == 32'h8000_0008 && we[0]) begin
      m_txv = 1; m_txd = wdata[7:0];
    end
    if (sel && w == 32'h8000_0018 && we != 0) begin
      m_cyc = 0; m_inst = 0;
    end else begin
      m_cyc = m_cyc + 1;
      if (retire) m_inst = m_inst + 1;
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    chk("rdata", rdata, m_rdata);
    chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_txv});
    chk("tx_data", {24'd0, tx_data}, {24'd0, m_txd});
    chk("rx_ready", {31'd0, rx_ready}, {31'd0, m_q.size() < RX_DEPTH});
  endtask

  task automatic idle_inputs();
    re = 0; we = 0; addr = 0; wdata = 0;
  endtask

  task automatic load(input logic [31:0] a);
    addr = a; re = 1; we = 0;
    tick();
    idle_inputs();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] e);
    addr = a; wdata = d; we = e; re = 0;
    tick();
    idle_inputs();
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_txv", {31'd0, tx_valid}, 32'd0);
    chk("rst_rxready", {31'd0, rx_ready}, 32'd1);
    load(32'h8000_0000);
    chk("rst_status", rdata, 32'h1);

    // Counters: 12 cycles after reset, 5 retirements
    do_reset();
    for (int i = 0; i < 12; i++) begin
      retire = (i % 2 == 0) && (i < 10);
      tick();
    end
    retire = 0;
    load(32'h8000_0010);
    chk("cyc12", rdata, 32'd12);
    load(32'h8000_0014);
    chk("inst5", rdata, 32'd5);

    // TX handshake
    tx_ready = 0;
    store(32'h8000_0008, 32'h41, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      load(32'h8000_0000);
      chk("tx_hold_data", {24'd0, tx_data}, 32'h41);
      chk("tx_status_busy", rdata, 32'h0);
    end
    store(32'h8000_0008, 32'h42, 4'b0001);
    chk("tx_full_drop", {24'd0, tx_data}, 32'h41);
    tx_ready = 1;
    store(32'h8000_0008, 32'h43, 4'b0001);
    tx_ready = 0;
    chk("tx_cleared", {31'd0, tx_valid}, 32'd0);
    load(32'h8000_0000);
    chk("tx_status_ready", rdata, 32'h1);
    // Status read in the handshake cycle reports busy
    store(32'h8000_0008, 32'h44, 4'b0001);
    tx_ready = 1;
    load(32'h8000_0000);
    tx_ready = 0;
    chk("tx_status_hs", rdata, 32'h0);
    chk("tx_hs_clear", {31'd0, tx_valid}, 32'd0);

    // RX fill and drain
    rx_valid = 1;
    for (int i = 0; i < 4; i++) begin
      rx_data = 8'h10 + 8'(i);
      tick();
    end
    chk("rx_full_ready", {31'd0, rx_ready}, 32'd0);
    rx_data = 8'h14;
    tick();
    rx_valid = 0;
    for (int i = 0; i < 4; i++) begin
      load(32'h8000_0004);
      chk("rx_drain", rdata, 32'h10 + i);
    end
    load(32'h8000_0004);
    chk("rx_empty_read", rdata, 32'h0);
    load(32'h8000_0000);
    chk("rx_status_empty", rdata, 32'h1);

    // Pointer wrap with simultaneous push and pop
    rx_valid = 1;
    rx_data = 8'h20; tick();
    rx_data = 8'h21; tick();
    for (int i = 0; i < 6; i++) begin
      rx_data = 8'h22 + 8'(i);
      load(32'h8000_0004);
      chk("wrap_order", rdata, 32'h20 + i);
      chk("wrap_count", {31'd0, rx_ready}, 32'd1);
    end
    rx_valid = 0;
    load(32'h8000_0004);
    chk("wrap_tail0", rdata, 32'h26);
    load(32'h8000_0004);
    chk("wrap_tail1", rdata, 32'h27);

    // Non-I/O isolation
    rx_valid = 1;
    rx_data = 8'h30; tick();
    rx_data = 8'h31; tick();
    rx_valid = 0;
    load(32'h1000_0004);
    chk("nonio_rdata", rdata, 32'h27);
    load(32'h8000_0004);
    chk("nonio_nopop", rdata, 32'h30);
    store(32'h0000_0008, 32'h55, 4'b0001);
    chk("nonio_tx", {31'd0, tx_valid}, 32'd0);

    // Counter clear beats same-cycle increment
    retire = 1;
    store(32'h8000_0018, 32'h0, 4'b0100);
    retire = 0;
    load(32'h8000_0014);
    chk("clr_inst", rdata, 32'h0);

    // Cycle counter wrap
    force dut.cyc_cnt_q = 32'hFFFF_FFFF;
    m_cyc = 32'hFFFF_FFFF;
    addr = 32'h8000_0010; re = 1;
    #2;
    release dut.cyc_cnt_q;
    tick();
    chk("cyc_max", rdata, 32'hFFFF_FFFF);
    tick();
    idle_inputs();
    chk("cyc_wrap", rdata, 32'h0);

    // Reset mid-operation
    store(32'h8000_0008, 32'h77, 4'b0001);
    rx_valid = 1; rx_data = 8'h99; tick(); rx_valid = 0;
    rst = 1; addr = 32'h8000_0010; re = 1;
    tick();
    rst = 0; idle_inputs();
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_txv", {31'd0, tx_valid}, 32'd0);
    load(32'h8000_0000);
    chk("midrst_status", rdata, 32'h1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int op;
      logic [31:0] offs;
      op = $urandom_range(0, 9);
      offs = 32'(4 * $urandom_range(0, 8));
      idle_inputs();
      tx_ready = ($urandom_range(0, 2) == 0);
      rx_valid = ($urandom_range(0, 1) == 0);
      rx_data = 8'($urandom);
      retire = $urandom_range(0, 1) == 1;
      rst = ($urandom_range(0, 99) == 0);
      if (op < 4) begin
        addr = 32'h8000_0000 | offs; re = 1;
      end else if (op < 6) begin
        addr = 32'h8000_0008 | 32'($urandom_range(0, 3)); wdata = $urandom;
        we = 4'($urandom_range(0, 15));
      end else if (op == 6) begin
        addr = 32'h8000_0018; we = 4'($urandom_range(1, 15));
      end else if (op == 7) begin
        addr = {4'($urandom_range(0, 7)), 28'($urandom)}; re = 1;
      end else if (op == 8) begin
        addr = {4'h1, 24'd0, offs[3:0]}; we = 4'hF; wdata = $urandom;
      end
      if (op >= 4 && op <= 6 && offs[2]) begin
        addr = 32'h8000_0000 | offs; wdata = $urandom;
        we = 4'($urandom_range(1, 15));
      end
      tick();
    end
    rst = 0; idle_inputs(); rx_valid = 0; tx_ready = 0; retire = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
